conv_mem_responder: RTL
=======================

Name: conv_mem_responder

Overview:
- Responder (memory side) of the convolution accelerator's image and layer-memory interface.
- Serves image pixels on iaddr/idata and implements the five csel-selected layer banks (L0 kernel0/1, L1 kernel0/1, L2 flattened).
- Performs the ready/busy start handshake with the accelerator.
- Gives the host image preload, result read-back, write counting and protocol error flags. Used as the synthesizable memory subsystem and as the golden bench model.

Parameters:
DW, 20, data width of image and layer words
L0_DEPTH, 4096, words per layer-0 bank (csel 1, 2)
L1_DEPTH, 1024, words per layer-1 bank (csel 3, 4)
L2_DEPTH, 2048, words in layer-2 bank (csel 5)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  host request to launch one accelerator run
ready  output  1  start request to accelerator
busy  input  1  accelerator busy
done  output  1  one-cycle pulse when the run ends
iaddr  input  12  image read address from accelerator
idata  output  DW  image pixel at iaddr, signed
img_we  input  1  host image preload write enable
img_waddr  input  12  host image preload address
img_wdata  input  DW  host image preload data
crd  input  1  layer-memory read enable
caddr_rd  input  12  layer-memory read address
cdata_rd  output  DW  layer-memory read data
cwr  input  1  layer-memory write enable
caddr_wr  input  12  layer-memory write address
cdata_wr  input  DW  layer-memory write data
csel  input  3  bank select: 1..5 valid; 0, 6, 7 invalid
err  output  1  sticky protocol error
wr_cnt  output  16  accepted layer writes in current run, saturating
dbg_sel  input  3  host read-back bank select
dbg_addr  input  12  host read-back address
dbg_data  output  DW  host read-back data

Behaviour:
- Reset (reset=0, async):
  - FSM goes to IDLE; ready=0, done=0, err=0, wr_cnt=0.
  - Memory contents are not cleared.
- FSM states IDLE, REQ, RUN, DONE:
  - IDLE: start=1 -> REQ; clears err and wr_cnt at that edge.
  - REQ: ready=1; busy sampled 1 -> RUN, ready drops the next cycle. ready stays high while busy=0, with no timeout.
  - RUN: busy sampled 0 -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
  - start outside IDLE is ignored.
- Image port:
  - idata = image[iaddr], combinational (zero-latency). The accelerator samples idata in the same cycle it drives iaddr.
  - img_we writes image[img_waddr] at posedge, only in IDLE. img_we in any other state: write dropped, err set.
- Layer read:
  - cdata_rd is combinational from the bank selected by csel at caddr_rd when crd=1, else 0.
  - Invalid csel, or caddr_rd >= depth of the selected bank: returns 0 and sets err.
- Layer write:
  - At posedge when cwr=1, bank[csel][caddr_wr] <= cdata_wr.
  - Invalid csel or out-of-range address: write dropped, err set, wr_cnt not incremented.
  - Each accepted write increments wr_cnt, saturating at 16'hFFFF.
- crd and cwr in the same cycle: both are served. If they target the same bank and address, cdata_rd returns the old value (read-before-write).
- crd or cwr while not in RUN: still served, and err is set. This covers the accelerator writing after busy drops.
- err is sticky until reset or a new start is accepted.
- Debug read-back:
  - dbg_data is combinational: dbg_sel=0 selects image; dbg_sel 1..5 select the layer banks.
  - Invalid dbg_sel or out-of-range address returns 0. Does not set err.
- Address mapping: the bank index is the low log2(depth) bits of a 12-bit address. Addresses with set bits above the bank depth count as out of range.

Test Plan:
- Handshake: reset, start=1 for 1 cycle, hold busy=0 for 5 cycles -> ready stays 1. Then busy=1 -> ready=0 the next cycle. Then busy=0 -> done=1 for exactly one cycle, FSM back in IDLE.
- Image serve: preload image[12'h041]=20'hFFFF0 in IDLE; in RUN drive iaddr=12'h041 -> idata=20'hFFFF0 in the same cycle.
- Bank routing: in RUN write csel=1, addr 4095, 20'h00123 and csel=4, addr 1023, 20'h0ABCD -> dbg reads return those values; wr_cnt=2; err=0.
- Boundaries: cwr with csel=3, caddr_wr=12'd1024 -> dropped, err=1. crd with csel=6 -> cdata_rd=0. A following start clears err to 0.
- Simultaneous access: csel=5 addr 2047 holds 20'h00001; same cycle crd and cwr to addr 2047 with 20'h00002 -> cdata_rd=20'h00001, next read returns 20'h00002.
- Reset mid-run: assert reset=0 in RUN with ready/done/err set -> all outputs 0 immediately, FSM IDLE, previously written bank data still readable via dbg.

Source files
------------

// File: rtl/conv_mem_responder.sv
// Memory-side responder for the conv accelerator: image port, five layer banks, start handshake, host preload/debug.
// Reads are combinational (zero latency); writes land at posedge. There is no backpressure: REQ holds ready until busy rises.
// Protocol violations are still served where possible and raise a sticky err.
module conv_mem_responder #(
    parameter int DW       = 20,
    parameter int L0_DEPTH = 4096,
    parameter int L1_DEPTH = 1024,
    parameter int L2_DEPTH = 2048
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          ready,
    input  logic          busy,
    output logic          done,
    input  logic [11:0]   iaddr,
    output logic [DW-1:0] idata,
    input  logic          img_we,
    input  logic [11:0]   img_waddr,
    input  logic [DW-1:0] img_wdata,
    input  logic          crd,
    input  logic [11:0]   caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic          cwr,
    input  logic [11:0]   caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic [2:0]    csel,
    output logic          err,
    output logic [15:0]   wr_cnt,
    input  logic [2:0]    dbg_sel,
    input  logic [11:0]   dbg_addr,
    output logic [DW-1:0] dbg_data
);
    localparam int L0_AW = $clog2(L0_DEPTH);
    localparam int L1_AW = $clog2(L1_DEPTH);
    localparam int L2_AW = $clog2(L2_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RUN, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic        err_q, err_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    logic [DW-1:0] img_mem  [4096];
    logic [DW-1:0] l0k0_mem [L0_DEPTH];
    logic [DW-1:0] l0k1_mem [L0_DEPTH];
    logic [DW-1:0] l1k0_mem [L1_DEPTH];
    logic [DW-1:0] l1k1_mem [L1_DEPTH];
    logic [DW-1:0] l2_mem   [L2_DEPTH];

    logic rd_ok, wr_ok, img_wr_ok, start_acc, err_now;

    // Any address bit at or above the bank depth makes the access out of range.
    function automatic logic in_range(input logic [2:0] sel, input logic [11:0] addr);
        case (sel)
            3'd1, 3'd2: return int'(addr) < L0_DEPTH;
            3'd3, 3'd4: return int'(addr) < L1_DEPTH;
            3'd5:       return int'(addr) < L2_DEPTH;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [DW-1:0] bank_rd(input logic [2:0] sel, input logic [11:0] addr);
        case (sel)
            3'd1:    return l0k0_mem[addr[L0_AW-1:0]];
            3'd2:    return l0k1_mem[addr[L0_AW-1:0]];
            3'd3:    return l1k0_mem[addr[L1_AW-1:0]];
            3'd4:    return l1k1_mem[addr[L1_AW-1:0]];
            3'd5:    return l2_mem[addr[L2_AW-1:0]];
            default: return '0;
        endcase
    endfunction

    always_comb begin
        rd_ok     = in_range(csel, caddr_rd);
        wr_ok     = cwr && in_range(csel, caddr_wr);
        img_wr_ok = img_we && (state_q == ST_IDLE);
        start_acc = start && (state_q == ST_IDLE);

        idata    = img_mem[iaddr];
        cdata_rd = (crd && rd_ok) ? bank_rd(csel, caddr_rd) : '0;
        if (dbg_sel == 3'd0) begin
            dbg_data = img_mem[dbg_addr];
        end else begin
            dbg_data = in_range(dbg_sel, dbg_addr) ? bank_rd(dbg_sel, dbg_addr) : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_REQ;
            ST_REQ:  if (busy)  state_d = ST_RUN;
            ST_RUN:  if (!busy) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase

        // Accesses outside RUN are still served but flagged (e.g. late writes after busy drops).
        err_now = (img_we && !img_wr_ok)
                | (crd && !rd_ok)
                | (cwr && !wr_ok)
                | ((crd || cwr) && (state_q != ST_RUN));

        err_d    = (start_acc ? 1'b0 : err_q) | err_now;
        wr_cnt_d = start_acc ? 16'd0 : wr_cnt_q;
        if (wr_ok && (wr_cnt_d != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_d + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b0;
            wr_cnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Storage is deliberately not reset so contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (img_wr_ok)               img_mem[img_waddr]              <= img_wdata;
        if (wr_ok && csel == 3'd1)   l0k0_mem[caddr_wr[L0_AW-1:0]]   <= cdata_wr;
        if (wr_ok && csel == 3'd2)   l0k1_mem[caddr_wr[L0_AW-1:0]]   <= cdata_wr;
        if (wr_ok && csel == 3'd3)   l1k0_mem[caddr_wr[L1_AW-1:0]]   <= cdata_wr;
        if (wr_ok && csel == 3'd4)   l1k1_mem[caddr_wr[L1_AW-1:0]]   <= cdata_wr;
        if (wr_ok && csel == 3'd5)   l2_mem[caddr_wr[L2_AW-1:0]]     <= cdata_wr;
    end

    assign ready  = (state_q == ST_REQ);
    assign done   = (state_q == ST_DONE);
    assign err    = err_q;
    assign wr_cnt = wr_cnt_q;
endmodule
